// File: rtl/ntt_ctrl_if.sv
// Issue/write-back signal bundle between the NTT sequencer and its host datapath.
// The slave side is the controller; the master side supplies start/direction/stall.
interface ntt_ctrl_if;
    logic       start_i;
    logic       intt_i;
    logic       stall_i;
    logic       busy_o;
    logic       done_o;
    logic       rd_en_o;
    logic [3:0] rd_iter_o;
    logic [2:0] layer_o;
    logic [7:0] len_o;
    logic [6:0] zeta_addr_o;
    logic       wr_en_o;
    logic [3:0] wr_iter_o;
    logic [2:0] wr_layer_o;

    modport master (
        output start_i, intt_i, stall_i,
        input  busy_o, done_o, rd_en_o, rd_iter_o, layer_o, len_o, zeta_addr_o,
               wr_en_o, wr_iter_o, wr_layer_o
    );

    modport slave (
        input  start_i, intt_i, stall_i,
        output busy_o, done_o, rd_en_o, rd_iter_o, layer_o, len_o, zeta_addr_o,
               wr_en_o, wr_iter_o, wr_layer_o
    );
endinterface

// File: rtl/ntt_ctrl.sv
// Seven-layer NTT/INTT sequencer: issues 16 butterfly reads per layer, waits out the
// butterfly latency between layers and mirrors each read onto a delayed write-back.
module ntt_ctrl #(
    parameter int BU_LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ntt_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(BU_LAT - 1);
    localparam int         PIPE_LAST  = BU_LAT - 1;

    state_t     state_q, state_d;
    logic       intt_q;
    logic [2:0] k_q;
    logic [3:0] iter_q;
    logic [3:0] drain_q;
    logic [2:0] layer_q;
    logic [7:0] len_q;
    logic       rd_en;
    logic       start_acc;
    logic       enter_drain;
    logic       next_layer;
    logic [7:0] pipe_q [BU_LAT];

    function automatic logic [2:0] phys_layer(input logic inv, input logic [2:0] k);
        return inv ? 3'd6 - k : k;
    endfunction

    function automatic logic [7:0] layer_len(input logic [2:0] layer);
        return 8'd128 >> layer;
    endfunction

    always_comb begin
        state_d     = state_q;
        rd_en       = 1'b0;
        start_acc   = 1'b0;
        enter_drain = 1'b0;
        next_layer  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_acc = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.stall_i) begin
                    rd_en = 1'b1;
                    if (iter_q == 4'd15) begin
                        enter_drain = 1'b1;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (k_q == 3'd6) begin
                        state_d = DONE;
                    end else begin
                        next_layer = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // iter stays at 15 through DRAIN so the read-side address outputs keep their last value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            intt_q  <= 1'b0;
            k_q     <= '0;
            iter_q  <= '0;
            drain_q <= '0;
            layer_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                intt_q  <= bus.intt_i;
                k_q     <= '0;
                iter_q  <= '0;
                layer_q <= phys_layer(bus.intt_i, 3'd0);
                len_q   <= layer_len(phys_layer(bus.intt_i, 3'd0));
            end else if (next_layer) begin
                k_q     <= k_q + 3'd1;
                iter_q  <= '0;
                layer_q <= phys_layer(intt_q, k_q + 3'd1);
                len_q   <= layer_len(phys_layer(intt_q, k_q + 3'd1));
            end else if (rd_en && !enter_drain) begin
                iter_q <= iter_q + 4'd1;
            end
            if (enter_drain) begin
                drain_q <= '0;
            end else if (state_q == DRAIN) begin
                drain_q <= drain_q + 4'd1;
            end
        end
    end

    // Write-back pipe: {valid, iter, layer} delayed by the butterfly latency, never stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BU_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {rd_en, iter_q, layer_q};
            for (int i = 1; i < BU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
    assign bus.rd_en_o     = rd_en;
    assign bus.rd_iter_o   = iter_q;
    assign bus.layer_o     = layer_q;
    assign bus.len_o       = len_q;
    assign bus.zeta_addr_o = {layer_q, iter_q};
    assign bus.wr_en_o     = pipe_q[PIPE_LAST][7];
    assign bus.wr_iter_o   = pipe_q[PIPE_LAST][6:3];
    assign bus.wr_layer_o  = pipe_q[PIPE_LAST][2:0];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: three latency builds share one stimulus stream, each checked
// against a read/write schedule model derived from layer and iteration arithmetic.
module tb_ntt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic intt = 1'b0;
    logic stall = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 15;

        ntt_ctrl_if bus();
        assign bus.start_i = start;
        assign bus.intt_i  = intt;
        assign bus.stall_i = stall;

        ntt_ctrl #(.BU_LAT(LAT)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus.slave)
        );

        bit         active = 1'b0;
        bit         inv = 1'b0;
        bit         was_idle, exp_rd, exp_wr, exp_done;
        int         j = 0;
        int         e = 0;
        int         done_cyc = 0;
        int         t_start = 0;
        int         obs_rd = 0;
        int         obs_wr = 0;
        int         done_rel = -1;
        int         lay;
        int         wq_cyc[$];
        logic [6:0] wq_tag[$];
        logic [6:0] tag;

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("L%0d rst busy", LAT), 32'(bus.busy_o), 0);
                chk($sformatf("L%0d rst done", LAT), 32'(bus.done_o), 0);
                chk($sformatf("L%0d rst rd_en", LAT), 32'(bus.rd_en_o), 0);
                chk($sformatf("L%0d rst wr_en", LAT), 32'(bus.wr_en_o), 0);
                chk($sformatf("L%0d rst addr", LAT),
                    {bus.rd_iter_o, bus.layer_o, bus.len_o, bus.zeta_addr_o,
                     bus.wr_iter_o, bus.wr_layer_o}, 0);
                active = 1'b0;
                wq_cyc.delete();
                wq_tag.delete();
            end else begin
                was_idle = !active;
                exp_rd   = active && j < 112 && cyc >= e && !stall;
                exp_wr   = wq_cyc.size() > 0 && wq_cyc[0] == cyc;
                exp_done = active && j == 112 && cyc == done_cyc;

                chk($sformatf("L%0d rd_en", LAT), 32'(bus.rd_en_o), 32'(exp_rd));
                if (exp_rd) begin
                    lay = inv ? 6 - j / 16 : j / 16;
                    chk($sformatf("L%0d rd_iter", LAT), 32'(bus.rd_iter_o), j % 16);
                    chk($sformatf("L%0d layer", LAT), 32'(bus.layer_o), lay);
                    chk($sformatf("L%0d len", LAT), 32'(bus.len_o), 128 >> lay);
                    chk($sformatf("L%0d zeta", LAT), 32'(bus.zeta_addr_o), lay * 16 + j % 16);
                end
                chk($sformatf("L%0d wr_en", LAT), 32'(bus.wr_en_o), 32'(exp_wr));
                if (exp_wr) begin
                    tag = wq_tag.pop_front();
                    void'(wq_cyc.pop_front());
                    chk($sformatf("L%0d wr_iter", LAT), 32'(bus.wr_iter_o), 32'(tag[6:3]));
                    chk($sformatf("L%0d wr_layer", LAT), 32'(bus.wr_layer_o), 32'(tag[2:0]));
                end
                chk($sformatf("L%0d busy", LAT), 32'(bus.busy_o), 32'(active));
                chk($sformatf("L%0d done", LAT), 32'(bus.done_o), 32'(exp_done));

                if (active && bus.rd_en_o) obs_rd++;
                if (active && bus.wr_en_o) obs_wr++;
                if (bus.done_o) done_rel = cyc - t_start;

                if (exp_done) begin
                    chk($sformatf("L%0d rd count", LAT), obs_rd, 112);
                    chk($sformatf("L%0d wr count", LAT), obs_wr, 112);
                    active = 1'b0;
                end
                if (exp_rd) begin
                    lay = inv ? 6 - j / 16 : j / 16;
                    wq_cyc.push_back(cyc + LAT);
                    wq_tag.push_back({4'(j % 16), 3'(lay)});
                    j++;
                    if (j == 112) done_cyc = cyc + LAT + 1;
                    else e = (j % 16 == 0) ? cyc + 1 + LAT : cyc + 1;
                end
                if (was_idle && start) begin
                    active   = 1'b1;
                    inv      = intt;
                    j        = 0;
                    e        = cyc + 1;
                    t_start  = cyc;
                    obs_rd   = 0;
                    obs_wr   = 0;
                    done_rel = -1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic dir);
        intt  = dir;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;

        // Forward and inverse, no stalls
        pulse_start(1'b0);
        step(240);
        chk("fwd done L4", g_lat[0].done_rel, 141);
        chk("fwd done L1", g_lat[1].done_rel, 7 * 17 + 1);
        chk("fwd done L15", g_lat[2].done_rel, 7 * 31 + 1);
        pulse_start(1'b1);
        step(240);
        chk("inv done L4", g_lat[0].done_rel, 141);

        // Three stalled issue cycles at layer 2, iter 5 of the BU_LAT=4 build
        pulse_start(1'b0);
        step(45);
        stall = 1'b1;
        step(3);
        stall = 1'b0;
        step(240);
        chk("stall done L4", g_lat[0].done_rel, 144);

        // Stall across the first drain and a start pulse while busy
        pulse_start(1'b0);
        step(16);
        stall = 1'b1;
        step(4);
        stall = 1'b0;
        step(9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(240);
        chk("drain stall done L4", g_lat[0].done_rel, 141);

        // Randomized stall/start traffic
        for (int t = 0; t < 3; t++) begin
            pulse_start(1'($urandom_range(0, 1)));
            for (int c = 0; c < 320; c++) begin
                stall = ($urandom_range(0, 3) == 0);
                start = (c < 100) && ($urandom_range(0, 40) == 0);
                intt  = 1'($urandom_range(0, 1));
                step(1);
            end
            stall = 1'b0;
            start = 1'b0;
            step(300);
        end

        // Reset in the middle of a transform, then a clean restart
        pulse_start(1'b0);
        step(49);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        pulse_start(1'b1);
        step(240);
        chk("post-rst done L4", g_lat[0].done_rel, 141);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter BU_LAT, default 4 (range 1..15): butterfly-unit read-to-write-back latency in cycles.
REQ-002 SHALL have ports:
- clk_i, input, 1: the single clock; all logic on its rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- start_i, input, 1: request a full 7-layer transform; sampled only in IDLE.
- intt_i, input, 1: direction, captured with start_i; 0 = forward NTT, 1 = inverse NTT.
- stall_i, input, 1: blocks issue of new reads; does not affect the write-back pipe.
- busy_o, output, 1: high whenever state is not IDLE.
- done_o, output, 1: one-cycle completion pulse.
- rd_en_o, output, 1: issue butterfly read for 8 BUs this cycle.
- rd_iter_o, output, 4: iteration index within the layer, 0..15.
- layer_o, output, 3: current physical layer, 0..6.
- len_o, output, 8: butterfly distance, 128 >> layer_o.
- zeta_addr_o, output, 7: {layer_o, rd_iter_o} address into the zeta ROM banks.
- wr_en_o, output, 1: write back 8 BU results this cycle.
- wr_iter_o, output, 4: iteration index of the write-back.
- wr_layer_o, output, 3: layer of the write-back.

Function
REQ-003 SHALL implement a state machine with states IDLE, ISSUE, DRAIN and DONE.
REQ-004 In IDLE, start_i=1 SHALL capture intt_i, set the logical layer k=0 and iter=0, and enter ISSUE on the next cycle.
REQ-005 In IDLE, start_i=0 SHALL keep the controller in IDLE. start_i SHALL be ignored in every other state; no queuing.
REQ-006 Physical layer SHALL be layer_o = k for forward and layer_o = 6-k for inverse, so len_o runs 128→2 forward and 2→128 inverse.
REQ-007 In ISSUE with stall_i=0: rd_en_o=1 combinationally; rd_iter_o=iter; iter increments at the clock edge.
REQ-008 In ISSUE with stall_i=1: rd_en_o=0 and iter holds.
REQ-009 ISSUE with iter=15 and stall_i=0 SHALL transition to DRAIN with the drain counter cleared.
REQ-010 DRAIN SHALL last exactly BU_LAT cycles, so the last write-back of a layer precedes the first read of the next layer.
REQ-011 When DRAIN finishes with k<6: k increments, iter=0, and the state returns to ISSUE.
REQ-012 When DRAIN finishes with k=6: the state goes to DONE.
REQ-013 DONE SHALL assert done_o for exactly one cycle, then return to IDLE. busy_o=1 in DONE.
REQ-014 The write-back pipe SHALL be a BU_LAT-deep shift register of {rd_en_o, rd_iter_o, layer_o} driving {wr_en_o, wr_iter_o, wr_layer_o}. It shifts every cycle regardless of stall_i.
REQ-015 With no stalls, wr_en_o SHALL pulse exactly BU_LAT cycles after each rd_en_o pulse, with matching iter and layer.
REQ-016 zeta_addr_o, len_o and layer_o SHALL be valid whenever rd_en_o=1. Their values are don't-care otherwise, but they hold their last value.
REQ-017 Per layer SHALL produce exactly 16 rd_en_o and 16 wr_en_o pulses; per transform, 112 of each.
REQ-018 Stall-free transform latency SHALL be as follows:
- start accepted at cycle 0;
- layer k issues on cycles 1+k*(16+BU_LAT) .. 16+k*(16+BU_LAT);
- done_o on cycle 7*(16+BU_LAT)+1.
REQ-019 Stall cycles SHALL extend total latency by exactly the number of stalled ISSUE cycles. stall_i in DRAIN, DONE or IDLE SHALL have no effect.

Reset
REQ-020 rst_i=1 SHALL immediately force the following, independent of clk_i:
- state = IDLE;
- all outputs = 0;
- k = 0, iter = 0, drain counter = 0;
- the write-back pipe fully cleared.
REQ-021 Reset mid-transform SHALL abort the transform: no wr_en_o and no done_o afterwards until a new start_i is accepted.
REQ-022 The first start_i after reset deassertion SHALL be accepted in the first cycle rst_i=0 is sampled.

Verification
REQ-023 Forward, BU_LAT=4, no stall: start_i at cycle 0, intt_i=0 → expected response:
- layer_o 0..6, len_o 128,64,..,2;
- rd_en_o high on cycles 1-16, 21-36, ..., 121-136;
- done_o on cycle 141; busy_o high on cycles 1-141.
REQ-024 Inverse: start_i with intt_i=1 → expected response:
- layer_o sequence 6,5,..,0 and len_o 2..128;
- zeta_addr_o on the first issue = 7'h60, on the last issue = 7'h0F.
REQ-025 Stall: stall_i=1 for 3 cycles at layer 2, iter 5 → expected response:
- rd_iter_o resumes at 5 with no skip or repeat;
- wr_en_o count still 112;
- done_o on cycle 144.
REQ-026 Stall outside ISSUE and ignored start: stall_i held high throughout DRAIN plus a start_i pulse while busy → expected response: timing unchanged from REQ-023 and no second transform.
REQ-027 Reset mid-operation: rst_i asserted at cycle 50 → expected response:
- all outputs 0 within the same cycle;
- no wr_en_o in the following 20 cycles;
- a new start completes after a further 140 cycles.
REQ-028 BU_LAT=1 and BU_LAT=15 builds: per-layer period 17 and 31 cycles; the wr→rd layer ordering of REQ-010 holds.
